// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter slice.
//   pc_op_e   - per-cycle operation chosen by the PC.
//   pc_decode - priority decode of the raw control inputs into pc_op_e.
//   depth_w   - width of a counter that holds 0..depth inclusive.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_SEQ    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JUMP   = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_op_e;

    // Highest priority first: stall, ret, call, jump, branch, otherwise sequential.
    function automatic pc_op_e pc_decode(input logic stall,
                                         input logic ret,
                                         input logic call,
                                         input logic jump,
                                         input logic branch);
        if (stall)       return PC_HOLD;
        else if (ret)    return PC_RET;
        else if (call)   return PC_CALL;
        else if (jump)   return PC_JUMP;
        else if (branch) return PC_BRANCH;
        else             return PC_SEQ;
    endfunction

    function automatic int depth_w(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/pc_unit_ret_stack.sv
// ret_stack: parametrised LIFO holding return addresses.
//   CLK, RESET  - clock and asynchronous active-high reset (clears depth only).
//   push, push_data - store push_data on top; ignored when full.
//   pop         - discard the top entry; ignored when empty.
//   top         - entry at depth-1 (don't-care when empty).
//   depth, full, empty - occupancy, decoded from the registered depth.
module ret_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int DEPTH_W    = depth_w(STACK_DEPTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               push,
    input  logic               pop,
    input  logic [ADDR_W-1:0]  push_data,
    output logic [ADDR_W-1:0]  top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    assign full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // Entry storage carries no reset: entries at or above depth are never read.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && !full && (depth == DEPTH_W'(i))) begin
                mem[i] <= push_data;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth == DEPTH_W'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with a hardware return-address stack.
//   CLK, RESET - clock and asynchronous active-high reset.
//   stall/ret/call/jump/branch - control requests, priority in that order.
//   offset     - signed branch offset, relative to address+1.
//   target     - absolute destination for jump and call.
//   address    - registered current instruction address.
//   depth, stack_empty, stack_full - stack occupancy (registered).
//   overflow, underflow - sticky error flags, cleared only by RESET.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               ADDR_W      = 8,
    parameter int               OFF_W       = 8,
    parameter int               STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              stall,
    input  logic                              branch,
    input  logic [OFF_W-1:0]                  offset,
    input  logic                              jump,
    input  logic                              call,
    input  logic                              ret,
    input  logic [ADDR_W-1:0]                 target,
    output logic [ADDR_W-1:0]                 address,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  depth,
    output logic                              stack_empty,
    output logic                              stack_full,
    output logic                              overflow,
    output logic                              underflow
);

    pc_op_e                   op;
    logic [ADDR_W-1:0]        inc;
    logic signed [OFF_W-1:0]  off_s;
    logic signed [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0]        next_addr;
    logic [ADDR_W-1:0]        top;
    logic                     push;
    logic                     pop;

    assign op  = pc_decode(stall, ret, call, jump, branch);
    assign inc = address + ADDR_W'(1);

    // Casting a signed operand to a wider size sign-extends it.
    assign off_s   = offset;
    assign off_ext = ADDR_W'(off_s);

    assign push = (op == PC_CALL) && !stack_full;
    assign pop  = (op == PC_RET)  && !stack_empty;

    always_comb begin
        next_addr = inc;
        case (op)
            PC_HOLD:   next_addr = address;
            PC_SEQ:    next_addr = inc;
            PC_BRANCH: next_addr = inc + $unsigned(off_ext);
            PC_JUMP:   next_addr = target;
            PC_CALL:   next_addr = target;
            // An empty-stack return falls through to the sequential address.
            PC_RET:    next_addr = stack_empty ? inc : top;
            default:   next_addr = inc;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            address   <= RESET_ADDR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            address <= next_addr;
            if ((op == PC_CALL) && stack_full) overflow  <= 1'b1;
            if ((op == PC_RET) && stack_empty) underflow <= 1'b1;
        end
    end

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push),
        .pop       (pop),
        .push_data (inc),
        .top       (top),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter with a hardware return-address stack. It sits at the front of the fetch path. Each clock it chooses the next instruction address from one of these sources: sequential, PC-relative branch, absolute jump, call or return. It also supports stalls and reports stack overflow and underflow.

## Interface
Parameters:
- ADDR_W, 8, width of the instruction address.
- OFF_W, 8, width of the signed branch offset; constraint OFF_W <= ADDR_W.
- STACK_DEPTH, 4, number of return-address entries; must be >= 1.
- RESET_ADDR, 0, value loaded into address on reset.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- stall  in  1  hold all state this cycle.
- branch  in  1  take a PC-relative branch.
- offset  in  OFF_W  two's-complement branch offset.
- jump  in  1  absolute jump to target.
- call  in  1  push the return address and jump to target.
- ret  in  1  pop the return address into address.
- target  in  ADDR_W  absolute destination for jump and call.
- address  out  ADDR_W  current instruction address (registered).
- depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_empty  out  1  depth == 0.
- stack_full  out  1  depth == STACK_DEPTH.
- overflow  out  1  sticky flag: a call was made while the stack was full.
- underflow  out  1  sticky flag: a ret was made while the stack was empty.

## Operation
- Decoded operation per cycle, highest priority first: stall, ret, call, jump, branch, seq. Only the winning operation takes effect.
- Next-address arithmetic is modulo 2^ADDR_W.
- Let inc = address + 1; offset is sign-extended to ADDR_W before use.
- seq: address <= inc.
- branch: address <= inc + sext(offset).
- jump: address <= target.
- call, stack not full: push inc; address <= target; depth increments.
- call, stack full: address <= target; no push; stack contents and depth unchanged; overflow <= 1.
- ret, stack not empty: address <= top-of-stack entry; pop; depth decrements.
- ret, stack empty: address <= inc; overflow and depth unchanged; underflow <= 1.
- stall: address, stack, depth and both flags hold, whatever the other inputs are.
- The stack is a strict LIFO. Entries above depth are don't-care and are never observed.
- overflow and underflow are cleared only by RESET.

## Timing
- All outputs are registered. Inputs sampled at rising edge N take effect at address, depth and the flags after edge N. Latency is one cycle, with no bubbles.
- stack_empty and stack_full are decoded from the registered depth, so they change in the same cycle as depth.
- RESET asserted: immediately, with no clock edge needed, address = RESET_ADDR, depth = 0, stack_empty = 1, stack_full = 0, overflow = 0, underflow = 0.
- RESET released: the first update happens on the next rising edge.
- RESET asserted in the middle of a call/ret sequence discards all stack contents.
- There is no combinational path from any input to any output.

## Structure
- Shared package pc_pkg holds:
  - the operation encoding (PC_HOLD, PC_SEQ, PC_BRANCH, PC_JUMP, PC_CALL, PC_RET);
  - a priority-decode function mapping {stall, ret, call, jump, branch} to that encoding.
- One sub-module, ret_stack: a parametrised LIFO with push, pop, top, depth, full and empty. Its ports are CLK and RESET with the same asynchronous reset. pc_unit never issues push and pop in the same cycle.
- pc_unit contains the decode logic, the next-address mux, the address register and the sticky flags.

## Test plan
All scenarios use ADDR_W=8, OFF_W=8, STACK_DEPTH=2 and RESET_ADDR=0.
- Async reset: run to address 0x05, then raise RESET between clock edges. Required: address = 0x00 with no edge, stack_empty = 1, flags = 0.
- Branch arithmetic:
  - at 0x10, branch with offset 0x05: next address is 0x16;
  - at 0x16, branch with offset 0xFE: next address is 0x15;
  - at 0x02, branch with offset 0xF0: next address is 0xF3 (wrap).
- Sequential wrap: at 0xFF with no control asserted, the next address is 0x00.
- Call/return stack, in order from address 0x20:
  - call target 0x80: address 0x80, depth 1;
  - call target 0x90: address 0x90, depth 2, stack_full = 1;
  - call target 0xA0: address 0xA0, overflow = 1, depth stays 2;
  - ret: address 0x81;
  - ret: address 0x21, stack_empty = 1;
  - ret: address 0x22, underflow = 1.
- Stall: at 0x40 with depth 1, assert stall together with ret, call and branch. Required: address, depth and flags all unchanged after the edge.
- Priority: at 0x30 with depth 1 and top entry 0x55, assert ret, call (target 0x99) and branch in the same cycle. Required: address = 0x55, depth = 0, no push.
